tile_renderer: RTL

TILE_RENDERER -- requirements
Module: tile_renderer

---
 rtl/tile_renderer_pkg.sv | 29 ++
 rtl/tile_renderer_if.sv | 12 +
 rtl/tile_fifo.sv | 39 +++
 rtl/tile_renderer.sv | 81 ++++++++
 4 files changed

// File: rtl/tile_renderer_pkg.sv
// tile_renderer_pkg: shared tile codes, colours, grid size and FIFO entry type
package tile_renderer_pkg;
  typedef enum logic [2:0] {
    OBJ_EMPTY  = 3'd0,
    OBJ_HEAD   = 3'd1,
    OBJ_BODY   = 3'd2,
    OBJ_APPLE  = 3'd3,
    OBJ_BORDER = 3'd4
  } obj_code_t;
  localparam logic [15:0] RGB_EMPTY  = 16'h0000;
  localparam logic [15:0] RGB_HEAD   = 16'hFFE0;
  localparam logic [15:0] RGB_BODY   = 16'h07E0;
  localparam logic [15:0] RGB_APPLE  = 16'hF800;
  localparam logic [15:0] RGB_BORDER = 16'h001F;
  localparam logic [4:0] GRID_W = 5'd16;
  localparam logic [4:0] GRID_H = 5'd12;
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] code;
  } tile_entry_t;
  typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;
  function automatic logic [15:0] code_color(input logic [2:0] c);
    return c == OBJ_HEAD   ? RGB_HEAD   :
           c == OBJ_BODY   ? RGB_BODY   :
           c == OBJ_APPLE  ? RGB_APPLE  :
           c == OBJ_BORDER ? RGB_BORDER : RGB_EMPTY;
  endfunction
endpackage

// File: rtl/tile_renderer_if.sv
// tile_renderer_if: pixel stream valid/ready bus from renderer to display writer
interface tile_renderer_if;
  logic        px_valid;
  logic        px_ready;
  logic [8:0]  px_x;
  logic [7:0]  px_y;
  logic [15:0] px_color;
  logic        px_first;
  logic        px_last;
  modport master(output px_valid, px_x, px_y, px_color, px_first, px_last, input px_ready);
  modport slave(input px_valid, px_x, px_y, px_color, px_first, px_last, output px_ready);
endinterface

// File: rtl/tile_fifo.sv
// tile_fifo: registered-output-count FIFO with no fall-through, generic entry type
module tile_fifo
  import tile_renderer_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = tile_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(rd);
      count  <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/tile_renderer.sv
// tile_renderer: queues tile updates and rasterises each tile as a row-major pixel stream
module tile_renderer
  import tile_renderer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TILE_PX    = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             diff,
  input  logic [3:0]       x,
  input  logic [3:0]       y,
  input  logic [2:0]       obj_code,
  output logic             scan_en,
  output logic             busy,
  output logic             overflow,
  tile_renderer_if.master  px
);
  localparam int CW = $clog2(TILE_PX);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  tile_entry_t din, head;
  logic full, empty, in_range, push, pop, hs, last_col;
  logic [NW-1:0] count;
  logic [3:0] tx, ty;
  logic [15:0] color;
  logic [CW-1:0] col, row;
  assign din      = '{x, y, obj_code};
  assign in_range = {1'b0, x} < GRID_W && {1'b0, y} < GRID_H;
  assign push     = diff && in_range && !full;
  tile_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(tile_entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  assign scan_en     = count < NW'(FIFO_DEPTH - 1);
  assign busy        = !empty || state != IDLE;
  assign hs          = px.px_valid && px.px_ready;
  assign last_col    = col == CW'(TILE_PX - 1);
  assign px.px_valid = state == DRAW;
  assign px.px_x     = px.px_valid ? 9'(tx) * 9'(TILE_PX) + 9'(col) : '0;
  assign px.px_y     = px.px_valid ? 8'(ty) * 8'(TILE_PX) + 8'(row) : '0;
  assign px.px_color = px.px_valid ? color : '0;
  assign px.px_first = px.px_valid && col == '0 && row == '0;
  assign px.px_last  = px.px_valid && last_col && row == CW'(TILE_PX - 1);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    pop     = state == LOAD;
    state_n = state == IDLE ? (empty ? IDLE : LOAD) :
              state == LOAD ? DRAW :
              (hs && px.px_last ? IDLE : DRAW);
  end
  always_ff @(posedge clk)
    if (rst) begin
      tx       <= '0;
      ty       <= '0;
      color    <= '0;
      col      <= '0;
      row      <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow || (diff && in_range && full);
      if (pop) begin
        tx    <= head.x;
        ty    <= head.y;
        color <= code_color(head.code);
        col   <= '0;
        row   <= '0;
      end else if (hs) begin
        col <= last_col ? '0 : col + 1'b1;
        row <= last_col ? row + 1'b1 : row;
      end
    end
endmodule
